// File: rtl/warmboot_sequencer.sv
// Sequences an iCE40 warmboot: drain SPI/USB traffic, detach from USB, settle the image select, then fire BOOT.
// Optional macro WARMBOOT_DRAIN_TIMEOUT_EN bounds the drain wait to DRAIN_TIMEOUT cycles and flags drain_timeout.
module warmboot_sequencer #(
  parameter int DETACH_CYCLES = 48000,
  parameter int SETTLE_CYCLES = 16,
  parameter int DRAIN_TIMEOUT = 480000
) (
  input  logic       clk_48mhz,
  input  logic       reset,
  input  logic       boot_req,
  input  logic [1:0] boot_image,
  input  logic       spi_busy,
  input  logic       usb_tx_en,
  output logic       boot_ack,
  output logic       spi_hold_off,
  output logic       usb_pu,
  output logic       wb_s1,
  output logic       wb_s0,
  output logic       wb_boot,
  output logic       busy,
  output logic       drain_timeout
);

  localparam int DETACH_EFF = (DETACH_CYCLES < 1) ? 1 : DETACH_CYCLES;
  localparam int SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam int MAX_COUNT  = (DETACH_EFF > SETTLE_EFF) ? DETACH_EFF : SETTLE_EFF;
  localparam int CNT_W      = $clog2(MAX_COUNT + 1);

  typedef enum logic [2:0] {IDLE, DRAIN, DETACH, SETTLE, FIRE} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             drain_expired;
  logic             timeout_next;
  logic             accept;

  assign accept = (state == IDLE) && boot_req;

`ifdef WARMBOOT_DRAIN_TIMEOUT_EN
  localparam int DRAIN_EFF = (DRAIN_TIMEOUT < 1) ? 1 : DRAIN_TIMEOUT;
  localparam int DT_W      = $clog2(DRAIN_EFF + 1);

  logic [DT_W-1:0] drain_cnt, drain_cnt_next;

  // Counts completed DRAIN cycles; expiry fires on the DRAIN_TIMEOUT-th DRAIN edge.
  assign drain_expired = (drain_cnt == DT_W'(DRAIN_EFF - 1));

  always_comb begin
    drain_cnt_next = drain_cnt;
    if (accept)
      drain_cnt_next = '0;
    else if (state == DRAIN && !drain_expired)
      drain_cnt_next = drain_cnt + DT_W'(1);
  end

  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) drain_cnt <= '0;
    else       drain_cnt <= drain_cnt_next;
  end
`else
  logic unused_drain_timeout_param;
  assign unused_drain_timeout_param = |DRAIN_TIMEOUT;
  assign drain_expired = 1'b0;
`endif

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    timeout_next = drain_timeout;
    case (state)
      IDLE: begin
        if (boot_req) state_next = DRAIN;
      end
      // A clean drain wins over a coincident timeout, so drain_timeout stays clear then.
      DRAIN: begin
        if (!spi_busy && !usb_tx_en) begin
          state_next = DETACH;
          cnt_next   = CNT_W'(DETACH_EFF);
        end else if (drain_expired) begin
          state_next   = DETACH;
          cnt_next     = CNT_W'(DETACH_EFF);
          timeout_next = 1'b1;
        end
      end
      DETACH: begin
        if (cnt == CNT_W'(1)) begin
          state_next = SETTLE;
          cnt_next   = CNT_W'(SETTLE_EFF);
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      SETTLE: begin
        if (cnt == CNT_W'(1)) begin
          state_next = FIRE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      FIRE: state_next = FIRE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they change on the same edge as the state.
  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      boot_ack      <= 1'b0;
      spi_hold_off  <= 1'b0;
      usb_pu        <= 1'b1;
      wb_s1         <= 1'b0;
      wb_s0         <= 1'b0;
      wb_boot       <= 1'b0;
      busy          <= 1'b0;
      drain_timeout <= 1'b0;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      boot_ack      <= accept;
      spi_hold_off  <= (state_next != IDLE);
      busy          <= (state_next != IDLE);
      usb_pu        <= !(state_next inside {DETACH, SETTLE, FIRE});
      wb_boot       <= (state_next == FIRE);
      drain_timeout <= timeout_next;
      if (accept) begin
        wb_s1 <= boot_image[1];
        wb_s0 <= boot_image[0];
      end
    end
  end

endmodule

// File: tb/tb_warmboot_sequencer.sv
// Scoreboard bench for warmboot_sequencer: stimulus pushes the expected boot timeline, a monitor pops it when BOOT rises.
// Build with WARMBOOT_DRAIN_TIMEOUT_EN defined to exercise the drain timeout path.
module tb_warmboot_sequencer;

  localparam int DETACH_CYCLES = 10;
  localparam int SETTLE_CYCLES = 4;
  localparam int DRAIN_TIMEOUT = 20;
`ifdef WARMBOOT_DRAIN_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  logic       clk_48mhz = 1'b0;
  logic       reset = 1'b1;
  logic       boot_req = 1'b0;
  logic [1:0] boot_image = 2'b00;
  logic       spi_busy = 1'b0;
  logic       usb_tx_en = 1'b0;
  logic       boot_ack, spi_hold_off, usb_pu, wb_s1, wb_s0, wb_boot, busy, drain_timeout;

  warmboot_sequencer #(
    .DETACH_CYCLES(DETACH_CYCLES),
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .DRAIN_TIMEOUT(DRAIN_TIMEOUT)
  ) dut (
    .clk_48mhz(clk_48mhz),
    .reset(reset),
    .boot_req(boot_req),
    .boot_image(boot_image),
    .spi_busy(spi_busy),
    .usb_tx_en(usb_tx_en),
    .boot_ack(boot_ack),
    .spi_hold_off(spi_hold_off),
    .usb_pu(usb_pu),
    .wb_s1(wb_s1),
    .wb_s0(wb_s0),
    .wb_boot(wb_boot),
    .busy(busy),
    .drain_timeout(drain_timeout)
  );

  always #5 clk_48mhz = ~clk_48mhz;

  typedef struct {
    int         ack_edge;
    int         pu_fall_edge;
    int         boot_edge;
    logic [1:0] image;
    logic       timeout;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   edge_cnt = 0;

  always @(posedge clk_48mhz) edge_cnt <= edge_cnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, edge_cnt);
    end
  endtask

  // Monitor: observes outputs just after each edge and scores a whole boot sequence when BOOT rises.
  int   mon_ack_edge = -1;
  int   mon_pu_fall_edge = -1;
  int   mon_ack_count = 0;
  logic mon_prev_pu = 1'b1;
  logic mon_prev_boot = 1'b0;

  always @(posedge clk_48mhz) begin
    exp_t item;
    #1;
    if (reset) begin
      mon_ack_edge     = -1;
      mon_pu_fall_edge = -1;
      mon_ack_count    = 0;
      mon_prev_pu      = 1'b1;
      mon_prev_boot    = 1'b0;
    end else begin
      if (boot_ack) begin
        mon_ack_count++;
        mon_ack_edge = edge_cnt;
        checkOutput("busy_at_ack", busy, 1);
      end
      if (busy) checkOutput("hold_off_while_busy", spi_hold_off, 1);
      if (mon_prev_pu && !usb_pu) mon_pu_fall_edge = edge_cnt;
      if (!mon_prev_boot && wb_boot) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_boot: wb_boot rose at edge %0d with nothing expected", edge_cnt);
        end else begin
          item = exp_q.pop_front();
          checkOutput("ack_count", mon_ack_count, 1);
          checkOutput("ack_edge", mon_ack_edge, item.ack_edge);
          checkOutput("pu_fall_edge", mon_pu_fall_edge, item.pu_fall_edge);
          checkOutput("boot_edge", edge_cnt, item.boot_edge);
          checkOutput("image", {wb_s1, wb_s0}, item.image);
          checkOutput("drain_timeout", drain_timeout, item.timeout);
        end
      end
      mon_prev_pu   = usb_pu;
      mon_prev_boot = wb_boot;
    end
  end

  // One boot attempt: sb/ut are the cycles spi_busy/usb_tx_en stay high after acceptance.
  task automatic applyStimulus(input logic [1:0] img, input int sb, input int ut,
                               input bit hold_req, input bit extra_req, input bit reset_mid_settle);
    int   n, x, boot_e, e;
    bit   tmo;
    exp_t item;
    @(negedge clk_48mhz);
    reset = 1'b1; boot_req = 1'b0; spi_busy = 1'b0; usb_tx_en = 1'b0;
    #1;
    checkOutput("rst_usb_pu", usb_pu, 1);
    checkOutput("rst_outputs", {boot_ack, spi_hold_off, wb_s1, wb_s0, wb_boot, busy, drain_timeout}, 0);
    @(negedge clk_48mhz);
    reset = 1'b0;
    repeat ($urandom_range(0, 3)) @(negedge clk_48mhz);

    // Reference timeline: drain ends on the first edge after both sources have gone quiet.
    n   = edge_cnt + 1;
    x   = n + 1 + ((sb > ut) ? sb : ut);
    tmo = TIMEOUT_EN && (x > n + DRAIN_TIMEOUT);
    if (tmo) x = n + DRAIN_TIMEOUT;
    boot_e = x + DETACH_CYCLES + SETTLE_CYCLES;
    if (!reset_mid_settle) begin
      item.ack_edge = n; item.pu_fall_edge = x; item.boot_edge = boot_e;
      item.image = img; item.timeout = tmo;
      exp_q.push_back(item);
    end

    forever begin
      e = edge_cnt + 1;
      if (reset_mid_settle && e == x + DETACH_CYCLES + 2) begin
        checkOutput("pu_low_in_settle", usb_pu, 0);
        checkOutput("busy_in_settle", busy, 1);
        #1 reset = 1'b1;
        #1;
        checkOutput("async_rst_usb_pu", usb_pu, 1);
        checkOutput("async_rst_boot_busy", {wb_boot, busy}, 0);
        @(negedge clk_48mhz);
        reset = 1'b0;
        break;
      end
      if (e > boot_e + 3) break;
      spi_busy   = (e > n) && (e <= n + sb);
      usb_tx_en  = (e > n) && (e <= n + ut);
      boot_req   = hold_req || (e == n) || (extra_req && e == x + 3);
      boot_image = (e == n) ? img : (extra_req ? 2'b11 : 2'($urandom_range(0, 3)));
      @(negedge clk_48mhz);
    end

    if (!reset_mid_settle) begin
      checkOutput("boot_stays_high", wb_boot, 1);
      checkOutput("pu_stays_low", usb_pu, 0);
      checkOutput("timeout_sticky", drain_timeout, tmo);
      checkOutput("queue_drained", exp_q.size(), 0);
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    repeat (2) @(negedge clk_48mhz);
    applyStimulus(2'b10, 0, 0, 1'b0, 1'b0, 1'b0);
    applyStimulus(2'b01, 37, 0, 1'b0, 1'b0, 1'b0);
    applyStimulus(2'b00, 10, 15, 1'b0, 1'b0, 1'b0);
    applyStimulus(2'b10, 0, 0, 1'b0, 1'b1, 1'b0);
    applyStimulus(2'b11, 3, 0, 1'b0, 1'b0, 1'b1);
    applyStimulus(2'b01, 2, 1, 1'b1, 1'b0, 1'b0);
`ifdef WARMBOOT_DRAIN_TIMEOUT_EN
    applyStimulus(2'b11, 60, 0, 1'b0, 1'b0, 1'b0);
    applyStimulus(2'b10, 19, 0, 1'b0, 1'b0, 1'b0);
`endif
    for (int i = 0; i < 8; i++)
      applyStimulus(2'($urandom_range(0, 3)), $urandom_range(0, 30), $urandom_range(0, 30),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
